// File: rtl/alu_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_sched_pkg
// Purpose  : Shared constants and types for the ALU scheduler: datapath width,
//            opcode map (ALU ops 6'h00..6'h0E plus the internal divide) and
//            the scheduler FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_sched_pkg;

  localparam int DEF_WIDTH = 32;

  // Opcodes executed by the external ALU
  localparam logic [5:0] OPC_AND  = 6'h00;
  localparam logic [5:0] OPC_OR   = 6'h01;
  localparam logic [5:0] OPC_XOR  = 6'h02;
  localparam logic [5:0] OPC_NOT  = 6'h03;
  localparam logic [5:0] OPC_SHL  = 6'h04;
  localparam logic [5:0] OPC_SHR  = 6'h05;
  localparam logic [5:0] OPC_SRA  = 6'h06;
  localparam logic [5:0] OPC_ROL  = 6'h07;
  localparam logic [5:0] OPC_ROR  = 6'h08;
  localparam logic [5:0] OPC_SLT  = 6'h09;
  localparam logic [5:0] OPC_SLTU = 6'h0A;
  localparam logic [5:0] OPC_PASS = 6'h0B;
  localparam logic [5:0] OPC_ADD  = 6'h0C;
  localparam logic [5:0] OPC_SUB  = 6'h0D;
  localparam logic [5:0] OPC_CMP  = 6'h0E;

  // Opcode executed by the scheduler's own sequential divider
  localparam logic [5:0] OPC_DIV  = 6'h0F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage : alu_sched_pkg

`default_nettype wire

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module   : seq_divider
// Purpose  : Restoring divider, one quotient bit per cycle, MSB first, with a
//            WIDTH+1-bit partial remainder. Signed mode divides magnitudes and
//            fixes signs on the way out.
// Ports    : clk, rst_n          clock / async active-low reset
//            start               load a, b, sign and begin (one cycle)
//            a, b, sign          dividend, divisor, signed mode
//            busy                iterating
//            done                result valid this cycle (combinational)
//            quotient, rem       result, valid while done
//            dbz, ovf            divide-by-zero / signed overflow status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] rem,
  output logic             dbz,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_rem_sh, w_diff, w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx, w_rem_lo;
  logic             w_qbit, w_last;

  assign w_a_neg = sign & a[WIDTH-1];
  assign w_b_neg = sign & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // The dividend sits in quo_q and shifts out MSB first while quotient bits
  // shift in at the bottom. A borrow (diff MSB set) means "restore".
  assign w_rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, dvsr_q};
  assign w_qbit   = ~w_diff[WIDTH];
  assign w_rem_nx = w_qbit ? w_diff : w_rem_sh;
  assign w_quo_nx = {quo_q[WIDTH-2:0], w_qbit};
  assign w_rem_lo = w_rem_nx[WIDTH-1:0];
  assign w_last   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    dvnd_d = dvnd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    dbz_d  = 1'b0;
    ovf_d  = ovf_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (start) begin
      dvnd_d = a;
      dvsr_d = w_b_mag;
      quo_d  = w_a_mag;
      rem_d  = '0;
      cnt_d  = '0;
      negq_d = w_a_neg ^ w_b_neg;
      negr_d = w_a_neg;
      // Zero divisor skips iteration and reports on the next cycle
      dbz_d  = (b == '0);
      busy_d = (b != '0);
      ovf_d  = sign && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end else if (busy_q) begin
      rem_d = w_rem_nx;
      quo_d = w_quo_nx;
      cnt_d = cnt_q + CNT_W'(1);
      if (w_last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      dvnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      dvnd_q <= dvnd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      dbz_q  <= dbz_d;
      ovf_q  <= ovf_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  // Result is taken from the final step's next-state values so the caller
  // can register it on the same edge that completes the last iteration.
  assign busy     = busy_q;
  assign done     = w_last | dbz_q;
  assign quotient = dbz_q ? '1     : (negq_q ? -w_quo_nx : w_quo_nx);
  assign rem      = dbz_q ? dvnd_q : (negr_q ? -w_rem_lo : w_rem_lo);
  assign dbz      = dbz_q;
  assign ovf      = ovf_q;

endmodule : seq_divider

`default_nettype wire

// File: rtl/alu_scheduler.sv
//------------------------------------------------------------------------------
// Module   : alu_scheduler
// Purpose  : Round-robin arbiter sharing one combinational ALU between two
//            requesters; runs DIV on an internal sequential divider and
//            returns a registered result with a one-cycle response pulse.
// Ports    : clk, rst_n                    clock / async active-low reset
//            reqN_valid/ready/op/a/b/sign  request handshake, N = 0,1
//            respN_valid                   one-cycle response pulse
//            resp_result, resp_rem, resp_z/n/c/v  registered response
//            alu_a, alu_b, alu_op, alu_sign      registered ALU drive
//            alu_result, alu_z/n/c/v             ALU outputs
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int         WIDTH  = DEF_WIDTH,
  parameter logic [5:0] OP_DIV = OPC_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sign,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sign,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic [WIDTH-1:0] resp_rem,
  output logic             resp_z,
  output logic             resp_n,
  output logic             resp_c,
  output logic             resp_v,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [31:0]      alu_op,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [31:0]      alu_op_q, alu_op_d;
  logic             alu_sign_q, alu_sign_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [3:0]       flags_q, flags_d;    // {z, n, c, v}
  logic [1:0]       resp_valid_q, resp_valid_d;

  logic             w_idle, w_gnt0, w_gnt1, w_accept, w_is_div;
  logic [5:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a, w_sel_b;
  logic             w_sel_sign;
  logic             w_div_busy, w_div_done, w_div_dbz, w_div_ovf;
  logic [WIDTH-1:0] w_div_quo, w_div_rem;

  // Arbitration: a lone requester wins; on contention the one not granted
  // last time wins. Ready is held low while reset is asserted.
  assign w_idle     = (state_q == ST_IDLE);
  assign w_gnt0     = req0_valid & (~req1_valid | last_grant_q);
  assign w_gnt1     = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = rst_n & w_idle & w_gnt0;
  assign req1_ready = rst_n & w_idle & w_gnt1;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_op   = w_gnt0 ? req0_op   : req1_op;
  assign w_sel_a    = w_gnt0 ? req0_a    : req1_a;
  assign w_sel_b    = w_gnt0 ? req0_b    : req1_b;
  assign w_sel_sign = w_gnt0 ? req0_sign : req1_sign;
  assign w_is_div   = (w_sel_op == OP_DIV);

  seq_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_accept & w_is_div),
    .a        (w_sel_a),
    .b        (w_sel_b),
    .sign     (w_sel_sign),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_div_quo),
    .rem      (w_div_rem),
    .dbz      (w_div_dbz),
    .ovf      (w_div_ovf)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_sign_d   = alu_sign_q;
    result_d     = result_q;
    rem_d        = rem_q;
    flags_d      = flags_q;
    resp_valid_d = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          last_grant_d = req1_ready;
          owner_d      = req1_ready;
          if (w_is_div) begin
            // Divide-by-zero also passes through here for one cycle while
            // the divider presents its fixed result.
            state_d = ST_DIV_RUN;
          end else begin
            state_d    = ST_EXEC;
            alu_a_d    = w_sel_a;
            alu_b_d    = w_sel_b;
            alu_op_d   = {26'd0, w_sel_op};
            alu_sign_d = w_sel_sign;
          end
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        rem_d    = '0;
        flags_d  = {alu_z, alu_n, alu_c, alu_v};
        resp_valid_d[owner_q] = 1'b1;
        state_d  = ST_RESP;
      end
      ST_DIV_RUN: begin
        if (w_div_done) begin
          result_d = w_div_quo;
          rem_d    = w_div_rem;
          flags_d  = {(w_div_quo == '0), w_div_quo[WIDTH-1], 1'b0,
                      w_div_dbz | w_div_ovf};
          resp_valid_d[owner_q] = 1'b1;
          state_d  = ST_RESP;
        end else if (!w_div_busy) begin
          // Divider idle without a result: nothing to wait for
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_sign_q   <= 1'b0;
      result_q     <= '0;
      rem_q        <= '0;
      flags_q      <= '0;
      resp_valid_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_sign_q   <= alu_sign_d;
      result_q     <= result_d;
      rem_q        <= rem_d;
      flags_q      <= flags_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp_result = result_q;
  assign resp_rem    = rem_q;
  assign resp_z      = flags_q[3];
  assign resp_n      = flags_q[2];
  assign resp_c      = flags_q[1];
  assign resp_v      = flags_q[0];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_sign    = alu_sign_q;

endmodule : alu_scheduler

`default_nettype wire

// File: tb/tb_alu_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_scheduler
// Purpose  : Scoreboard bench for alu_scheduler: drivers push expected
//            responses, a monitor pops and compares on every response pulse.
//            Includes a stand-in ALU and a plain-arithmetic reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_scheduler;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic [3:0]  f;      // {z, n, c, v}
    int          lat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sign, req1_sign;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_result, resp_rem;
  logic        resp_z, resp_n, resp_c, resp_v;
  logic [31:0] alu_a, alu_b, alu_op, alu_result;
  logic        alu_sign, alu_z, alu_n, alu_c, alu_v;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sign(req1_sign),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_result(resp_result), .resp_rem(resp_rem),
    .resp_z(resp_z), .resp_n(resp_n), .resp_c(resp_c), .resp_v(resp_v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sign(alu_sign),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
    .alu_v(alu_v)
  );

  // Stand-in ALU: returns {result, z, n, c, v}. Any opcode bit, including
  // the upper zero-extension bits, changes the default-case result.
  function automatic logic [35:0] alu_fn(logic [31:0] op, logic [31:0] a,
                                         logic [31:0] b, logic sg);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      32'h00: r = a & b;
      32'h01: r = a | b;
      32'h0C: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      32'h0D: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = sg && (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: begin
        r = a ^ {b[15:0], b[31:16]} ^ op;
        c = op[0] ^ sg;
        v = a[31] & b[0];
      end
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  assign {alu_result, alu_z, alu_n, alu_c, alu_v} =
         alu_fn(alu_op, alu_a, alu_b, alu_sign);

  function automatic exp_t mk(logic [31:0] res, logic [31:0] rem,
                              logic [3:0] f, int lat);
    exp_t e;
    e.res = res; e.rem = rem; e.f = f; e.lat = lat; e.due = 0;
    return e;
  endfunction

  // Reference model: ALU ops come back 2 cycles after accept with rem 0;
  // DIV uses plain integer division, 33 cycles (2 when dividing by zero).
  function automatic exp_t model(logic [5:0] op, logic [31:0] a,
                                 logic [31:0] b, logic sg);
    logic [35:0] o;
    longint      sa, sb, q, r;
    logic [31:0] qq;
    logic        v;
    if (op != 6'h0F) begin
      o = alu_fn({26'd0, op}, a, b, sg);
      return mk(o[35:4], 32'd0, o[3:0], 2);
    end
    if (b == 32'd0) return mk(32'hFFFF_FFFF, a, 4'b0101, 2);
    v = 1'b0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      v  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
      q  = sa / sb;
      r  = sa % sb;
    end
    qq = q[31:0];
    return mk(qq, r[31:0], {(qq == 32'd0), qq[31], 1'b0, v}, 33);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic take(input int who);
    exp_t e;
    if ((who == 0 && q0.size() == 0) || (who == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL resp%0d_unexpected: got pulse at cycle %0d expected none",
               who, cyc);
      return;
    end
    if (who == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    chk($sformatf("resp%0d_result", who), 64'(resp_result), 64'(e.res));
    chk($sformatf("resp%0d_rem", who),    64'(resp_rem),    64'(e.rem));
    chk($sformatf("resp%0d_flags", who),
        64'({resp_z, resp_n, resp_c, resp_v}), 64'(e.f));
    chk($sformatf("resp%0d_cycle", who),  64'(cyc),         64'(e.due));
  endtask

  // Monitor: compare every pulse, and flag responses that never arrive
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp0_valid) take(0);
      if (resp1_valid) take(1);
      if (q0.size() > 0 && cyc > q0[0].due) begin
        chk("resp0_missing", 64'(cyc), 64'(q0[0].due));
        void'(q0.pop_front());
      end
      if (q1.size() > 0 && cyc > q1[0].due) begin
        chk("resp1_missing", 64'(cyc), 64'(q1[0].due));
        void'(q1.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that
  // accepted the request (acc = accept cycle, -1 on timeout).
  task automatic issue(input int who, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input exp_t e, output int acc);
    acc = -1;
    if (who == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_sign = sg; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_sign = sg; req1_valid = 1'b1;
    end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ((who == 0) ? req0_ready : req1_ready) begin
        acc   = cyc;
        e.due = cyc + e.lat;
        if (who == 0) q0.push_back(e);
        else          q1.push_back(e);
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL req%0d_ready_timeout: got no ready expected ready", who);
    end
    @(posedge clk);
    #1;
    if (who == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  task automatic rand_issue(input int who);
    logic [5:0]  op;
    logic [31:0] a, b;
    logic        sg;
    int          acc, r;
    if ($urandom_range(0, 4) == 0) return;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    r = int'($urandom_range(0, 9));
    if (r < 3)       op = 6'h0F;
    else if (r == 3) op = 6'($urandom_range(16, 63));
    else             op = 6'($urandom_range(0, 14));
    a  = $urandom;
    sg = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       b = 32'd0;
      1:       b = 32'($urandom_range(1, 15));
      2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      default: b = $urandom;
    endcase
    issue(who, op, a, b, sg, model(op, a, b, sg), acc);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (q0.size() + q1.size()) > 0; n++)
      @(posedge clk);
    chk("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_resp_valid"}, 64'({resp0_valid, resp1_valid}), 64'd0);
    chk({tag, "_resp_data"},  {resp_result, resp_rem}, 64'd0);
    chk({tag, "_resp_flags"}, 64'({resp_z, resp_n, resp_c, resp_v}), 64'd0);
    chk({tag, "_alu_ab"},     {alu_a, alu_b}, 64'd0);
    chk({tag, "_alu_op"},     64'({alu_op, alu_sign}), 64'd0);
    chk({tag, "_ready"},      64'({req0_ready, req1_ready}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, acc;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_sign = 1'b0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_sign = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention from reset: req0 first, req1 three cycles later; repeat
    fork
      issue(0, 6'h00, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0,
            model(6'h00, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0), acc0);
      issue(1, 6'h01, 32'h0000_00A5, 32'h5A00_0000, 1'b0,
            model(6'h01, 32'h0000_00A5, 32'h5A00_0000, 1'b0), acc1);
    join
    chk("arb_first_pair", 64'(acc1 - acc0), 64'd3);
    fork
      issue(0, 6'h0D, 32'd3, 32'd9, 1'b1, model(6'h0D, 32'd3, 32'd9, 1'b1), acc0);
      issue(1, 6'h0C, 32'hFFFF_FFFF, 32'd1, 1'b0,
            model(6'h0C, 32'hFFFF_FFFF, 32'd1, 1'b0), acc1);
    join
    chk("arb_second_pair", 64'(acc1 - acc0), 64'd3);

    // Directed values with hand-derived expectations
    issue(0, 6'h0C, 32'd5, 32'd7, 1'b0, mk(32'd12, 32'd0, 4'b0000, 2), acc);
    issue(1, 6'h0F, 32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 4'b0000, 33), acc);
    issue(0, 6'h0F, 32'hFFFF_FFF9, 32'd2, 1'b1,
          mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0100, 33), acc);
    issue(1, 6'h0F, 32'h1234, 32'd0, 1'b0,
          mk(32'hFFFF_FFFF, 32'h1234, 4'b0101, 2), acc);
    issue(0, 6'h0F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
          mk(32'h8000_0000, 32'd0, 4'b0101, 33), acc);
    drain();

    // Randomised traffic from both requesters
    for (int it = 0; it < 40; it++) begin
      fork
        rand_issue(0);
        rand_issue(1);
      join
    end
    drain();

    // Reset in the middle of a divide: outputs clear at once, no pulse
    issue(0, 6'h0F, 32'h1234_5678, 32'd3, 1'b0,
          model(6'h0F, 32'h1234_5678, 32'd3, 1'b0), acc);
    while (cyc < acc + 10) begin
      @(posedge clk);
      #1;
    end
    #2;
    q0.delete();
    q1.delete();
    req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_pulse", 64'({resp0_valid, resp1_valid}), 64'd0);
    end
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 6'h0C, 32'd1, 32'd1, 1'b0, mk(32'd2, 32'd0, 4'b0000, 2), acc);
    repeat (40) @(posedge clk);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_scheduler

`default_nettype wire
